mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
// Main control FSM for the multi-cycle MIPS datapath. Sequences one shared ALU, one unified
// instruction/data memory port, the IR and the register file over 3-5 cycles per instruction.
// Drives alu_op into ALU_control. Holds in memory states until mem_ready is high.
// PARAMETERS
// STALL_EN   1   1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
// clk          in   1  rising-edge clock
// rst_n        in   1  synchronous active-low reset
// opcode       in   6  IR[31:26], valid from DECODE onward
// mem_ready    in   1  memory handshake: read data valid / write accepted this cycle
// zero         in   1  ALU zero flag
// pc_en        out  1  PC load enable
// iord         out  1  memory address select: 0=PC, 1=ALUOut
// mem_read     out  1  memory read request
// mem_write    out  1  memory write request
// ir_write     out  1  IR load enable
// reg_dst      out  1  write register select: 0=rt, 1=rd
// mem_to_reg   out  1  write-back data select: 0=ALUOut, 1=MDR
// reg_write    out  1  register file write enable
// alu_src_a    out  1  0=PC, 1=A register
// alu_src_b    out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
// alu_op       out  2  00=add, 01=sub, 10=use funct (to ALU_control)
// pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
// instr_done   out  1  one-cycle pulse in final cycle of each instruction
// illegal_op   out  1  sticky: unsupported opcode decoded
// state        out  4  current state, for debug
// BEHAVIOUR
// - Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
// - States: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8
//   BRANCH=9 ADDIEX=10 ADDIWB=11 JUMP=12 TRAP=13. One state register; outputs decoded from state.
// - rst_n low at a clock edge: state<=IDLE, illegal_op<=0. This holds mid-instruction too; no
//   partial write completes after the reset edge. In IDLE every output is 0 (state=0).
// - IDLE->FETCH unconditionally on the first edge after rst_n goes high.
// - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//   ir_write=pc_en=mem_ready. Stays in FETCH while mem_ready=0; ->DECODE when mem_ready=1.
// - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
//   Next state: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->TRAP.
// - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. ->MEMRD for LW, ->MEMWR for SW.
// - MEMRD: mem_read=1, iord=1. Wait for mem_ready, then ->MEMWB.
// - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. ->FETCH.
// - MEMWR: mem_write=1, iord=1. Wait for mem_ready. instr_done=mem_ready. ->FETCH on accept.
// - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. ->ALUWB.
// - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. ->FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. ->FETCH.
// - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. ->ADDIWB.
// - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. ->FETCH.
// - JUMP: pc_src=10, pc_en=1, instr_done=1. ->FETCH.
// - TRAP: illegal_op=1 (sticky); all other outputs 0. Leaves TRAP only on reset.
// - Any output not listed for a state is 0 in that state.
// - mem_read and mem_write are never both 1. reg_write and pc_en never assert in the same cycle.
// - With mem_ready=1, cycles from FETCH to the instr_done cycle inclusive:
//   LW 5, SW/R/ADDI 4, BEQ/J 3. Each cycle mem_ready is low in a memory state adds one cycle.
// - STALL_EN=0: the mem_ready input is replaced by constant 1 everywhere.
// TESTING
// - Reset: rst_n=0 for 3 clk -> state=0, all outputs 0. Release -> FETCH one cycle later, mem_read=1.
// - R-type opcode=000000, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=10),ALUWB(reg_write=1,reg_dst=1); done at cycle 4.
// - LW with mem_ready low 2 cycles in FETCH and 1 in MEMRD -> 8 cycles total, ir_write high exactly 1 cycle.
// - BEQ zero=1 -> pc_en=1, pc_src=01 in BRANCH. zero=0 -> pc_en=0. alu_op=01 in both cases.
// - opcode=111111 -> TRAP, illegal_op=1 held 20 cycles, no writes. Then rst_n=0 -> illegal_op=0.
// - rst_n=0 during MEMWR while mem_ready=0 -> next cycle state=IDLE, mem_write=0, instr_done never pulses.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath.
// It sequences the shared ALU, the unified memory port, the IR and the register file,
// taking 3-5 cycles per instruction plus any memory wait cycles.
// There is one state register. The control outputs are decoded from the current state.
// A few outputs also follow mem_ready or zero in the same cycle, so that the PC/IR load
// and the branch decision happen in the cycle that needs them.

module mips_multicycle_ctrl #(
    parameter int STALL_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    state_t r_state;
    logic   r_illegal;
    logic   w_ready;

    // When stalling is disabled, every memory access completes in its first cycle.
    assign w_ready = (STALL_EN != 0) ? mem_ready : 1'b1;

    // State sequencing and the sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                // The IR holds the opcode steady, so it still selects between load and store here.
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (w_ready) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (w_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath control decode. Any output that a state does not drive stays 0.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = w_ready;
                pc_en     = w_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = w_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_op = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// It has three parts: a table of per-cycle vectors, hand-written multi-cycle sequences,
// and randomized instruction streams. The streams are checked against an instruction-path
// model that steps through each opcode's list of phases.

module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    mips_multicycle_ctrl #(.STALL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Per-state control word, in the same bit order as dut_vec().
    typedef struct packed {
        logic       pc_en, iord, mr, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       done;
    } ctl_t;
    ctl_t ctab [14];

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       rdy, z;
        logic [3:0] st;
        logic       pe, mr, mw, irw, rw, dn;
        logic [1:0] aop, psrc;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] dut_vec();
        return {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, state};
    endfunction

    function automatic ctl_t mk(input logic pe, input logic io, input logic mr, input logic mw,
                                input logic irw, input logic rd, input logic m2r, input logic rw,
                                input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                input logic [1:0] psrc, input logic dn);
        ctl_t c;
        c = {pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, dn};
        return c;
    endfunction

    // Expected outputs for a phase, given this cycle's handshake and zero flag.
    function automatic logic [20:0] expect_out(input int st, input logic rdy, input logic z);
        ctl_t c;
        c = ctab[st];
        if (st == 1) begin
            c.pc_en = rdy;
            c.irw   = rdy;
        end
        if (st == 6) c.done = rdy;
        if (st == 9) c.pc_en = z;
        return {c, (st == 13), 4'(st)};
    endfunction

    task automatic add(input logic rn, input logic [5:0] op, input logic rdy, input logic z,
                       input logic [3:0] st, input logic pe, input logic mr, input logic mw,
                       input logic irw, input logic rw, input logic dn,
                       input logic [1:0] aop, input logic [1:0] psrc);
        vec_t v;
        v.rst_n = rn; v.op = op; v.rdy = rdy; v.z = z; v.st = st;
        v.pe = pe; v.mr = mr; v.mw = mw; v.irw = irw; v.rw = rw; v.dn = dn;
        v.aop = aop; v.psrc = psrc;
        vq.push_back(v);
    endtask

    // Hold reset for three edges. Return on the negedge where IDLE is visible and rst_n is released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_idle", 32'(dut_vec()), 32'd0);
    endtask

    task automatic seq_lw_stall();
        int rs[8];
        int cyc, done_at, irw_cnt, viol;
        rs = '{0, 0, 1, 1, 1, 0, 1, 1};
        cyc = 0; done_at = 0; irw_cnt = 0; viol = 0;
        do_reset();
        while (done_at == 0 && cyc < 30) begin
            @(negedge clk);
            opcode = OP_LW;
            mem_ready = (cyc < 8) ? (rs[cyc] != 0) : 1'b1;
            #1;
            cyc++;
            if (cyc == 1) chk("release_fetch", 32'({state, mem_read}), 32'({4'd1, 1'b1}));
            if (ir_write) irw_cnt++;
            if ((mem_read && mem_write) || (reg_write && pc_en)) viol++;
            if (instr_done) done_at = cyc;
        end
        chk("lw_stall_cycles", 32'(done_at), 32'd8);
        chk("lw_irwrite_count", 32'(irw_cnt), 32'd1);
        chk("lw_exclusive", 32'(viol), 32'd0);
    endtask

    task automatic seq_trap();
        do_reset();
        opcode = 6'b111111;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("trap_hold%0d", i),
                32'({state, illegal_op, mem_write, reg_write, pc_en, ir_write, mem_read, instr_done}),
                32'({4'd13, 1'b1, 6'b0}));
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("trap_cleared", 32'({state, illegal_op}), 32'd0);
    endtask

    task automatic seq_memwr_reset();
        int done_cnt;
        done_cnt = 0;
        do_reset();
        opcode = OP_SW;
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (instr_done) done_cnt++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        if (instr_done) done_cnt++;
        chk("memwr_wait", 32'({state, mem_write, instr_done}), 32'({4'd6, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        chk("memwr_reset", 32'({state, mem_write, instr_done}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (instr_done) done_cnt++;
        end
        chk("memwr_no_done", 32'(done_cnt), 32'd0);
    endtask

    // Random instruction stream. Each opcode is a fixed list of phases. The memory phases
    // (fetch, load read, store write) repeat while mem_ready is low.
    task automatic random_stream(input int n_instr);
        int path[$];
        int pos, cyc, stalls, seen, st;
        logic [5:0] op;
        do_reset();
        for (int n = 0; n < n_instr; n++) begin
            case ($urandom_range(0, 5))
                0: begin op = OP_LW;   path = {1, 2, 3, 4, 5}; end
                1: begin op = OP_SW;   path = {1, 2, 3, 6};    end
                2: begin op = OP_R;    path = {1, 2, 7, 8};    end
                3: begin op = OP_BEQ;  path = {1, 2, 9};       end
                4: begin op = OP_ADDI; path = {1, 2, 10, 11};  end
                default: begin op = OP_J; path = {1, 2, 12};   end
            endcase
            pos = 0; cyc = 0; stalls = 0; seen = 0;
            while (pos < path.size() && cyc < 40) begin
                @(negedge clk);
                opcode = op;
                mem_ready = ($urandom_range(0, 3) != 0);
                zero = 1'($urandom_range(0, 1));
                #1;
                cyc++;
                st = path[pos];
                chk($sformatf("rand_i%0d_c%0d", n, cyc), 32'(dut_vec()),
                    32'(expect_out(st, mem_ready, zero)));
                if (instr_done && seen == 0) seen = cyc;
                if ((st == 1 || st == 4 || st == 6) && !mem_ready) stalls++;
                else pos++;
            end
            chk($sformatf("rand_i%0d_latency", n), 32'(seen), 32'(path.size() + stalls));
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;

        ctab[0]  = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        ctab[1]  = mk(0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        ctab[2]  = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
        ctab[3]  = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        ctab[4]  = mk(0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        ctab[5]  = mk(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1);
        ctab[6]  = mk(0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        ctab[7]  = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
        ctab[8]  = mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1);
        ctab[9]  = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1);
        ctab[10] = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        ctab[11] = mk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1);
        ctab[12] = mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1);
        ctab[13] = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);

        // Columns: rst_n op rdy z | state pc_en mem_read mem_write ir_write reg_write done alu_op pc_src
        add(0, OP_R,    1, 0,  4'd0, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_R,    1, 0,  4'd0, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_R,    1, 0,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_R,    1, 0,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_R,    1, 0,  4'd7, 0,0,0,0,0,0, 2'b10, 2'b00);
        add(1, OP_R,    1, 0,  4'd8, 0,0,0,0,1,1, 2'b00, 2'b00);
        add(1, OP_BEQ,  1, 1,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_BEQ,  1, 1,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_BEQ,  1, 1,  4'd9, 1,0,0,0,0,1, 2'b01, 2'b01);
        add(1, OP_BEQ,  1, 0,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_BEQ,  1, 0,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_BEQ,  1, 0,  4'd9, 0,0,0,0,0,1, 2'b01, 2'b01);
        add(1, OP_J,    1, 0,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_J,    1, 0,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_J,    1, 0,  4'd12,1,0,0,0,0,1, 2'b00, 2'b10);
        add(1, OP_SW,   1, 0,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_SW,   1, 0,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_SW,   1, 0,  4'd3, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_SW,   0, 0,  4'd6, 0,0,1,0,0,0, 2'b00, 2'b00);
        add(1, OP_SW,   1, 0,  4'd6, 0,0,1,0,0,1, 2'b00, 2'b00);
        add(1, OP_ADDI, 1, 0,  4'd1, 1,1,0,1,0,0, 2'b00, 2'b00);
        add(1, OP_ADDI, 1, 0,  4'd2, 0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_ADDI, 1, 0,  4'd10,0,0,0,0,0,0, 2'b00, 2'b00);
        add(1, OP_ADDI, 1, 0,  4'd11,0,0,0,0,1,1, 2'b00, 2'b00);
        add(0, OP_R,    0, 0,  4'd1, 0,1,0,0,0,0, 2'b00, 2'b00);

        repeat (3) @(posedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n = vq[i].rst_n; opcode = vq[i].op; mem_ready = vq[i].rdy; zero = vq[i].z;
            #1;
            chk($sformatf("vec%0d", i),
                32'({state, pc_en, mem_read, mem_write, ir_write, reg_write, instr_done, alu_op, pc_src}),
                32'({vq[i].st, vq[i].pe, vq[i].mr, vq[i].mw, vq[i].irw, vq[i].rw, vq[i].dn,
                     vq[i].aop, vq[i].psrc}));
        end

        seq_lw_stall();
        seq_trap();
        seq_memwr_reset();
        random_stream(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
